// File: rtl/line_buf_ctrl.sv
// Two-line RAM controller that presents 3-pixel vertical columns (rows r, r-1, r-2) of a raster stream.
// Latency: fixed 3 cycles from accepted pixel to out_valid.
// Backpressure: none; each stage carries its own valid, so input gaps produce matching output gaps.
module line_buf_ctrl #(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic        in_sof,
   input  logic [7:0]  in_data,
   output logic        bram0_we,
   output logic [10:0] bram0_addr,
   output logic [7:0]  bram0_din,
   input  logic [7:0]  bram0_dout,
   output logic        bram1_we,
   output logic [10:0] bram1_addr,
   output logic [7:0]  bram1_din,
   input  logic [7:0]  bram1_dout,
   output logic        out_valid,
   output logic [7:0]  out_p0,
   output logic [7:0]  out_p1,
   output logic [7:0]  out_p2,
   output logic [10:0] out_row,
   output logic [10:0] out_col,
   output logic        out_eof
);

   localparam logic [10:0] COL_LAST = 11'(WIDTH - 1);
   localparam logic [10:0] ROW_LAST = 11'(HEIGHT - 1);

   // raster position of the next pixel
   logic [10:0] col, row;
   // coordinates of the pixel on the input this cycle, and of the one after it
   logic [10:0] cur_col, cur_row, nxt_col, nxt_row;

   // stage 1: pixel whose previous-line value is arriving on bram0_dout
   logic        s1_vld;
   logic [10:0] s1_row, s1_col;
   logic [7:0]  s1_pix;

   // stage 2: previous-line value captured; line-2 value arriving on bram1_dout
   logic        s2_vld;
   logic [10:0] s2_row, s2_col;
   logic [7:0]  s2_p0, s2_p1;

   // start-of-frame forces the current pixel to (0,0); counters then step from there
   always_comb begin
      cur_col = col;
      cur_row = row;
      nxt_col = col;
      nxt_row = row;
      if (in_valid && in_sof) begin
         cur_col = '0;
         cur_row = '0;
      end
      if (cur_col == COL_LAST) begin
         nxt_col = '0;
         nxt_row = (cur_row == ROW_LAST) ? '0 : cur_row + 11'd1;
      end else begin
         nxt_col = cur_col + 11'd1;
         nxt_row = cur_row;
      end
   end

   // stage 0 RAM port: line-1 RAM is read (old data) and overwritten with the new pixel at the same column
   always_comb begin
      bram0_we   = in_valid & ~rst;
      bram0_addr = cur_col;
      bram0_din  = in_data;
   end

   // stage 1 RAM port: line-2 RAM receives the line-1 value just read, old line-2 value comes back next cycle
   always_comb begin
      bram1_we   = s1_vld & ~rst;
      bram1_addr = s1_col;
      bram1_din  = bram0_dout;
   end

   // input raster counters
   always_ff @(posedge clk) begin
      if (rst) begin
         col <= '0;
         row <= '0;
      end else if (in_valid) begin
         col <= nxt_col;
         row <= nxt_row;
      end
   end

   // stage 1 registers
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld <= 1'b0;
         s1_row <= '0;
         s1_col <= '0;
         s1_pix <= '0;
      end else begin
         s1_vld <= in_valid;
         if (in_valid) begin
            s1_row <= cur_row;
            s1_col <= cur_col;
            s1_pix <= in_data;
         end
      end
   end

   // stage 2 registers: capture the line-1 pixel from RAM 0
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_vld <= 1'b0;
         s2_row <= '0;
         s2_col <= '0;
         s2_p0  <= '0;
         s2_p1  <= '0;
      end else begin
         s2_vld <= s1_vld;
         if (s1_vld) begin
            s2_row <= s1_row;
            s2_col <= s1_col;
            s2_p0  <= s1_pix;
            s2_p1  <= bram0_dout;
         end
      end
   end

   // output registers: zero-pad rows above the frame top (RAM may hold a previous frame), hold when idle
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_eof   <= 1'b0;
         out_row   <= '0;
         out_col   <= '0;
         out_p0    <= '0;
         out_p1    <= '0;
         out_p2    <= '0;
      end else begin
         out_valid <= s2_vld;
         out_eof   <= s2_vld && (s2_row == ROW_LAST) && (s2_col == COL_LAST);
         if (s2_vld) begin
            out_row <= s2_row;
            out_col <= s2_col;
            out_p0  <= s2_p0;
            out_p1  <= (s2_row == 11'd0) ? 8'd0 : s2_p1;
            out_p2  <= (s2_row <  11'd2) ? 8'd0 : bram1_dout;
         end
      end
   end

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Bench for line_buf_ctrl: 4x3 instance checked against a frame-array reference model,
// plus a 2048-wide instance for the address wrap boundary.
// RAMs are modelled here as read-first, 1-cycle latency, preloaded with random stale data.
module tb_line_buf_ctrl;

   localparam int TW = 4;
   localparam int TH = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        fill = 1'b1;
   logic        in_valid = 1'b0, in_sof = 1'b0;
   logic [7:0]  in_data = '0;
   logic        bram0_we, bram1_we;
   logic [10:0] bram0_addr, bram1_addr;
   logic [7:0]  bram0_din, bram1_din, bram0_dout, bram1_dout;
   logic        out_valid, out_eof;
   logic [7:0]  out_p0, out_p1, out_p2;
   logic [10:0] out_row, out_col;

   logic        w_valid = 1'b0, w_sof = 1'b0;
   logic [7:0]  w_data = '0;
   logic        w_bram0_we, w_bram1_we;
   logic [10:0] w_bram0_addr, w_bram1_addr;
   logic [7:0]  w_bram0_din, w_bram1_din, w_bram0_dout, w_bram1_dout;
   logic        w_out_valid, w_out_eof;
   logic [7:0]  w_out_p0, w_out_p1, w_out_p2;
   logic [10:0] w_out_row, w_out_col;

   line_buf_ctrl #(.WIDTH(TW), .HEIGHT(TH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
      .bram0_we(bram0_we), .bram0_addr(bram0_addr), .bram0_din(bram0_din), .bram0_dout(bram0_dout),
      .bram1_we(bram1_we), .bram1_addr(bram1_addr), .bram1_din(bram1_din), .bram1_dout(bram1_dout),
      .out_valid(out_valid), .out_p0(out_p0), .out_p1(out_p1), .out_p2(out_p2),
      .out_row(out_row), .out_col(out_col), .out_eof(out_eof)
   );

   line_buf_ctrl #(.WIDTH(2048), .HEIGHT(3)) dut_w (
      .clk(clk), .rst(rst), .in_valid(w_valid), .in_sof(w_sof), .in_data(w_data),
      .bram0_we(w_bram0_we), .bram0_addr(w_bram0_addr), .bram0_din(w_bram0_din), .bram0_dout(w_bram0_dout),
      .bram1_we(w_bram1_we), .bram1_addr(w_bram1_addr), .bram1_din(w_bram1_din), .bram1_dout(w_bram1_dout),
      .out_valid(w_out_valid), .out_p0(w_out_p0), .out_p1(w_out_p1), .out_p2(w_out_p2),
      .out_row(w_out_row), .out_col(w_out_col), .out_eof(w_out_eof)
   );

   // read-first RAM models with a one-shot random preload
   logic [7:0] ram0 [0:2047];
   logic [7:0] ram1 [0:2047];
   logic [7:0] w_ram0 [0:2047];
   logic [7:0] w_ram1 [0:2047];

   always @(posedge clk) begin
      if (fill) begin
         for (int i = 0; i < 2048; i++) begin
            ram0[i]   <= 8'($urandom_range(1, 255));
            ram1[i]   <= 8'($urandom_range(1, 255));
            w_ram0[i] <= 8'($urandom_range(1, 255));
            w_ram1[i] <= 8'($urandom_range(1, 255));
         end
      end else begin
         bram0_dout   <= ram0[bram0_addr];
         bram1_dout   <= ram1[bram1_addr];
         w_bram0_dout <= w_ram0[w_bram0_addr];
         w_bram1_dout <= w_ram1[w_bram1_addr];
         if (bram0_we)   ram0[bram0_addr]     <= bram0_din;
         if (bram1_we)   ram1[bram1_addr]     <= bram1_din;
         if (w_bram0_we) w_ram0[w_bram0_addr] <= w_bram0_din;
         if (w_bram1_we) w_ram1[w_bram1_addr] <= w_bram1_din;
      end
   end

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // ---------------- reference model: frame image indexed by (row, col) ----------------
   typedef struct {
      int         due;
      int         row;
      int         col;
      logic [7:0] p0, p1, p2;
      logic       eof;
   } exp_t;

   exp_t       q[$];
   exp_t       last;
   logic [7:0] img [0:TH-1][0:TW-1];
   int         row_c = 0, col_c = 0;
   bit         prev_acc = 0;
   int         prev_col = 0;

   int         cap_p0 = -1, cap_p1 = -1, cap_p2 = -1, eof_p0 = -1, eof_cnt = 0;

   function automatic int model_accept(input bit s, input logic [7:0] d);
      exp_t e;
      int   r, c, idx;
      r = s ? 0 : row_c;
      c = s ? 0 : col_c;
      e.due = cyc + 3;
      e.row = r;
      e.col = c;
      e.p0  = d;
      e.p1  = (r == 0) ? 8'd0 : img[r-1][c];
      e.p2  = (r < 2)  ? 8'd0 : img[r-2][c];
      e.eof = (r == TH-1) && (c == TW-1);
      img[r][c] = d;
      q.push_back(e);
      idx   = (r * TW + c + 1) % (TW * TH);
      row_c = idx / TW;
      col_c = idx % TW;
      return c;
   endfunction

   task automatic check_outputs();
      bit   exp_v;
      exp_t e;
      exp_v = (q.size() > 0) && (q[0].due == cyc);
      chk("out_valid", 32'(out_valid), 32'(exp_v));
      if (exp_v) begin
         e = q.pop_front();
         chk("out_row", 32'(out_row), 32'(e.row));
         chk("out_col", 32'(out_col), 32'(e.col));
         chk("out_p0", 32'(out_p0), 32'(e.p0));
         chk("out_p1", 32'(out_p1), 32'(e.p1));
         chk("out_p2", 32'(out_p2), 32'(e.p2));
         chk("out_eof", 32'(out_eof), 32'(e.eof));
         last = e;
      end else begin
         chk("hold_p0", 32'(out_p0), 32'(last.p0));
         chk("hold_p1", 32'(out_p1), 32'(last.p1));
         chk("hold_p2", 32'(out_p2), 32'(last.p2));
         chk("hold_row", 32'(out_row), 32'(last.row));
         chk("hold_col", 32'(out_col), 32'(last.col));
         chk("idle_eof", 32'(out_eof), 32'd0);
      end
      if (out_valid === 1'b1 && out_row == 11'd2 && out_col == 11'd1) begin
         cap_p0 = out_p0;
         cap_p1 = out_p1;
         cap_p2 = out_p2;
      end
      if (out_valid === 1'b1 && out_eof === 1'b1) begin
         eof_p0 = out_p0;
         eof_cnt++;
      end
   endtask

   // one clock of main-instance stimulus with RAM-port and output checks
   task automatic tick(input bit v, input bit s, input logic [7:0] d, input bit r);
      int  c;
      bit  acc;
      in_valid = v;
      in_sof   = s;
      in_data  = d;
      rst      = r;
      #1;
      acc = v && !r;
      chk("bram0_we", 32'(bram0_we), 32'(acc));
      chk("bram1_we", 32'(bram1_we), 32'(prev_acc && !r));
      if (prev_acc && !r) chk("bram1_addr", 32'(bram1_addr), 32'(prev_col));
      c = 0;
      if (acc) begin
         c = model_accept(s, d);
         chk("bram0_addr", 32'(bram0_addr), 32'(c));
         chk("bram0_din", 32'(bram0_din), 32'(d));
      end
      prev_acc = acc;
      prev_col = c;
      if (r) begin
         q.delete();
         row_c = 0;
         col_c = 0;
         last  = '{default: 0};
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'd0, 1'b0);
   endtask

   initial begin
      last = '{default: 0};
      // reset and RAM preload
      tick(1'b0, 1'b0, 8'd0, 1'b1);
      fill = 1'b0;
      tick(1'b1, 1'b0, 8'd77, 1'b1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_p0", 32'(out_p0), 32'd0);
      chk("rst_out_row", 32'(out_row), 32'd0);
      idle(2);

      // continuous frame 1..12
      cap_p0 = -1; eof_p0 = -1; eof_cnt = 0;
      for (int p = 0; p < 12; p++) tick(1'b1, p == 0, 8'(p + 1), 1'b0);
      idle(4);
      chk("r2c1_p0", 32'(cap_p0), 32'd10);
      chk("r2c1_p1", 32'(cap_p1), 32'd6);
      chk("r2c1_p2", 32'(cap_p2), 32'd2);
      chk("eof_p0", 32'(eof_p0), 32'd12);
      chk("eof_cnt", 32'(eof_cnt), 32'd1);

      // same frame, in_valid every other cycle
      cap_p0 = -1;
      for (int p = 0; p < 12; p++) begin
         tick(1'b1, p == 0, 8'(p + 1), 1'b0);
         idle(1);
      end
      idle(4);
      chk("gap_r2c1_p0", 32'(cap_p0), 32'd10);
      chk("gap_r2c1_p2", 32'(cap_p2), 32'd2);

      // back-to-back frames; second frame's first rows must be padded
      for (int p = 0; p < 12; p++) tick(1'b1, p == 0, 8'(p + 1), 1'b0);
      for (int p = 0; p < 12; p++) tick(1'b1, p == 0, 8'(p + 101), 1'b0);
      idle(4);
      chk("f2_eof_p0", 32'(eof_p0), 32'd112);

      // mid-line restart at row 1 col 2
      for (int p = 0; p < 6; p++) tick(1'b1, p == 0, 8'(p + 31), 1'b0);
      for (int p = 0; p < 12; p++) tick(1'b1, p == 0, 8'(p + 51), 1'b0);
      idle(4);

      // reset in the cycle after the 5th pixel, then resume without sof
      for (int p = 0; p < 5; p++) tick(1'b1, p == 0, 8'(p + 201), 1'b0);
      tick(1'b1, 1'b0, 8'd99, 1'b1);
      chk("post_rst_valid", 32'(out_valid), 32'd0);
      chk("post_rst_p0", 32'(out_p0), 32'd0);
      for (int p = 0; p < 12; p++) tick(1'b1, 1'b0, 8'(p + 161), 1'b0);
      idle(4);

      // randomized frames with random gaps, one frame relying on counter wrap, one random reset
      for (int f = 0; f < 5; f++) begin
         int rpos;
         rpos = (f == 3) ? int'($urandom_range(1, 10)) : -1;
         for (int p = 0; p < 12; p++) begin
            idle(int'($urandom_range(0, 2)));
            if (p == rpos) tick(1'b0, 1'b0, 8'd0, 1'b1);
            tick(1'b1, (p == 0) && (f != 2), 8'($urandom), 1'b0);
         end
      end
      idle(5);
      chk("queue_drained", 32'(q.size()), 32'd0);

      // wide instance: address reaches 2047 and wraps, row increments exactly at the wrap
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 2051; i++) begin
         int j;
         w_valid = 1'b1;
         w_sof   = (i == 0);
         w_data  = 8'(i);
         #1;
         chk("w_addr0", 32'(w_bram0_addr), 32'(i % 2048));
         if (i >= 1) chk("w_addr1", 32'(w_bram1_addr), 32'((i - 1) % 2048));
         @(posedge clk);
         @(negedge clk);
         if (i >= 2) begin
            j = i - 2;
            chk("w_out_valid", 32'(w_out_valid), 32'd1);
            chk("w_out_col", 32'(w_out_col), 32'(j % 2048));
            chk("w_out_row", 32'(w_out_row), 32'(j / 2048));
            chk("w_out_p0", 32'(w_out_p0), 32'(j % 256));
         end
      end
      w_valid = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/line_buf_ctrl.md
LINE_BUF_CTRL -- requirements
Module: line_buf_ctrl

Interface
REQ-001 Parameter WIDTH, default 640: pixels per line; legal range 2..2048.
REQ-002 Parameter HEIGHT, default 480: lines per frame; legal range 3..2048.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  pixel strobe; one pixel accepted per cycle when high; no backpressure.
REQ-006 in_sof  input  1  start of frame; qualified by in_valid; marks the current pixel as (row 0, col 0).
REQ-007 in_data  input  8  pixel value.
REQ-008 bram0_we, bram1_we  output  1 each  write enable to line-buffer RAM 0 / RAM 1 (read-first RAM, 1-cycle read latency).
REQ-009 bram0_addr, bram1_addr  output  11 each  RAM address.
REQ-010 bram0_din, bram1_din  output  8 each  RAM write data.
REQ-011 bram0_dout, bram1_dout  input  8 each  RAM read data; old contents at the address presented one cycle earlier.
REQ-012 out_valid  output  1  a 3-pixel vertical column is present on the outputs.
REQ-013 out_p0, out_p1, out_p2  output  8 each  pixel at (row, col), (row-1, col), (row-2, col).
REQ-014 out_row, out_col  output  11 each  coordinates of out_p0.
REQ-015 out_eof  output  1  high with out_valid on the last pixel of a frame.

Function
REQ-016 Input counters col/row SHALL advance on each accepted pixel: col wraps WIDTH-1 -> 0 with row+1; at (HEIGHT-1, WIDTH-1) both wrap to 0.
REQ-017 in_valid with in_sof SHALL tag the pixel (0,0) and set the next counters to (0,1), regardless of counter state (mid-line restart allowed).
REQ-018 Stage 0 (cycle k, pixel accepted): bram0_addr=col, bram0_we=1, bram0_din=in_data, combinationally; bram0_we=0 when in_valid=0.
REQ-019 Stage 1 (cycle k+1): registered valid/row/col/pixel; bram1_addr=stage-1 col, bram1_din=bram0_dout, bram1_we=stage-1 valid.
REQ-020 Stage 2 (cycle k+2): registers capture bram0_dout as line-1 pixel; bram1_dout carries line-2 pixel.
REQ-021 Output registers SHALL load at edge ending cycle k+2; out_valid high in cycle k+3 (fixed latency 3), low otherwise.
REQ-022 Each stage SHALL carry its own valid; input gaps of any length SHALL produce matching out_valid gaps with no data corruption.
REQ-023 out_p1 SHALL be 0 when out_row=0; out_p2 SHALL be 0 when out_row<2 (zero padding, RAM contents ignored).
REQ-024 out_eof SHALL equal out_valid AND out_row=HEIGHT-1 AND out_col=WIDTH-1.
REQ-025 Outputs SHALL hold their last values while out_valid=0.
REQ-026 Address bits above log2(WIDTH) SHALL be 0; RAM port B is not driven by this block.

Reset
REQ-027 rst SHALL clear col, row, all stage valids and all output registers to 0; bram*_we SHALL be 0 during reset.
REQ-028 rst mid-line SHALL drop in-flight pixels (no out_valid for them); RAM contents are not cleared; padding of REQ-023 covers stale data.
REQ-029 After rst, the first accepted pixel SHALL be (0,0) with or without in_sof.

Verification
REQ-030 WIDTH=4, HEIGHT=3, in_sof+continuous pixels 1..12 -> out_valid 3 cycles later; row 2 col 1 gives p0=10, p1=6, p2=2; rows 0/1 padded; out_eof with p0=12.
REQ-031 Same frame with in_valid toggling every other cycle -> identical output sequence, out_valid 1 of every 2 cycles.
REQ-032 Two back-to-back frames, second pixels 101..112 -> second frame row 0 has p1=p2=0 despite RAM holding frame-1 data.
REQ-033 in_sof asserted at col 2 of row 1 -> that pixel reported as (0,0); next line's p1 equals restarted line's data.
REQ-034 rst asserted in cycle after 5th pixel -> no out_valid for pixels 1..5 after reset; next pixel reported at (0,0), outputs 0 during reset.
REQ-035 WIDTH=2048 boundary -> bram*_addr reaches 2047 then wraps to 0; row increments exactly at wrap.
